// File: rtl/pipe_pkg.sv
// Types and encodings shared by the memory and write-back stages of the RV32I pipeline.
package pipe_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } memwb_t;

endpackage

// File: rtl/mem_dmem.sv
// Word-addressed data memory: one combinational read port, one synchronous write port.
module mem_dmem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic          in_range,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; clearing it would need a per-word
  // reset network and contents are defined to survive rst.
  always_ff @(posedge clk) begin
    if (we && in_range) mem[idx] <= wdata;
  end

  assign rdata = in_range ? mem[idx] : 32'h0;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data memory, MEM/WB register and write-back mux.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FlushM,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic [31:0] ResultW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic        MisalignM
);

  exmem_t      exmem;
  memwb_t      memwb;
  logic [31:0] read_data;
  logic        in_range;

  // NOTE: pipeline state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || FlushM) begin
      exmem <= '0;
    end else begin
      exmem.reg_write  <= RegWriteE;
      exmem.mem_write  <= MemWriteE;
      exmem.result_src <= ResultSrcE;
      exmem.alu_result <= ALUResultE;
      exmem.write_data <= WriteDataE;
      exmem.pc_plus4   <= PCPlus4E;
      exmem.rd         <= RdE;
    end
  end

  assign in_range = (exmem.alu_result[31:AW+2] == '0);

  // The write uses the EX/MEM copy of mem_write, so a store in M completes
  // even on the edge where rst loads a bubble.
  mem_dmem #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
    .clk      (clk),
    .idx      (exmem.alu_result[AW+1:2]),
    .in_range (in_range),
    .we       (exmem.mem_write),
    .wdata    (exmem.write_data),
    .rdata    (read_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      memwb <= '0;
    end else begin
      memwb.reg_write  <= exmem.reg_write;
      memwb.result_src <= exmem.result_src;
      memwb.alu_result <= exmem.alu_result;
      memwb.read_data  <= read_data;
      memwb.pc_plus4   <= exmem.pc_plus4;
      memwb.rd         <= exmem.rd;
    end
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    ResultW = memwb.alu_result;
    case (memwb.result_src)
      RESULT_MEM: ResultW = memwb.read_data;
      RESULT_PC4: ResultW = memwb.pc_plus4;
      default:    ResultW = memwb.alu_result;
    endcase
  end

  assign ALUResultM = exmem.alu_result;
  assign RdM        = exmem.rd;
  assign RegWriteM  = exmem.reg_write;
  assign RdW        = memwb.rd;
  assign RegWriteW  = memwb.reg_write;
  assign MisalignM  = ((exmem.result_src == RESULT_MEM) || exmem.mem_write)
                      && (exmem.alu_result[1:0] != 2'b00);

endmodule
